// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch port and the
// data-memory port. DM wins by default, and a streak limit keeps fetch from starving.
module mem_port_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [2:0]  dm_funct3,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_funct3,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        if_valid,
   output logic        dm_valid,
   output logic [31:0] if_rdata,
   output logic [31:0] dm_rdata,
   output logic        stall_f,
   output logic        stall_m,
   output logic        bus_err
);

   // state   | meaning
   // IDLE    | no access in flight; arbitration happens here
   // BUSY_IF | fetch access owns the memory
   // BUSY_DM | load/store access owns the memory
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   localparam int          WW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   state_t        state;
   logic [2:0]    streak;
   logic [WW-1:0] wait_cnt;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [2:0]    lat_funct3;

   logic fetch_turn;
   logic grant_dm;
   logic grant_if;
   logic timeout_hit;

   assign fetch_turn  = if_req & (streak == 3'(MAX_STREAK));
   assign grant_dm    = dm_req & ~fetch_turn;
   assign grant_if    = if_req & ~grant_dm;
   assign timeout_hit = (wait_cnt == WW'(TIMEOUT - 1));

   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign mem_funct3 = lat_funct3;

   assign stall_f = if_req & ~if_valid;
   assign stall_m = dm_req & ~dm_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         streak     <= '0;
         wait_cnt   <= '0;
         bus_err    <= 1'b0;
         if_valid   <= 1'b0;
         dm_valid   <= 1'b0;
         if_rdata   <= NOP_INSN;
         dm_rdata   <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_funct3 <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (grant_dm) begin
                  state      <= BUSY_DM;
                  mem_req    <= 1'b1;
                  mem_we     <= dm_we;
                  lat_addr   <= dm_addr;
                  lat_wdata  <= dm_wdata;
                  lat_funct3 <= dm_funct3;
                  // Only DM wins taken while fetch is waiting count toward the streak.
                  if (!if_req)
                     streak <= '0;
                  else if (streak != 3'd7)
                     streak <= streak + 3'd1;
               end else if (grant_if) begin
                  state      <= BUSY_IF;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  lat_addr   <= if_addr;
                  lat_wdata  <= '0;
                  lat_funct3 <= 3'b010;
                  streak     <= '0;
               end
            end
            default: begin
               if (mem_ready || timeout_hit) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_ready)
                     bus_err <= 1'b1;
                  if (state == BUSY_IF) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_ready ? mem_rdata : NOP_INSN;
                  end else begin
                     dm_valid <= 1'b1;
                     dm_rdata <= mem_ready ? mem_rdata : 32'h0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of who owns the memory.
module tb_mem_port_arbiter;

   localparam int          MAX_STREAK = 4;
   localparam int          TIMEOUT    = 15;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [2:0]  dm_funct3;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        if_valid;
   logic        dm_valid;
   logic [31:0] if_rdata;
   logic [31:0] dm_rdata;
   logic        stall_f;
   logic        stall_m;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_funct3(dm_funct3),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .if_valid(if_valid), .dm_valid(dm_valid), .if_rdata(if_rdata), .dm_rdata(dm_rdata),
      .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Model: which port owns the memory (0 none, 1 fetch, 2 data), how long it has waited,
   // the operands captured at grant time, and the visible completion results.
   int          m_owner;
   int          m_waited;
   int          m_streak;
   logic [31:0] m_addr, m_wdata;
   logic [2:0]  m_f3;
   logic        m_we;
   logic        m_ifv, m_dmv, m_err;
   logic [31:0] m_if_rd, m_dm_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [31:0] rd;
      if (!reset) begin
         m_owner = 0; m_waited = 0; m_streak = 0;
         m_addr = 0; m_wdata = 0; m_f3 = 0; m_we = 0;
         m_ifv = 0; m_dmv = 0; m_err = 0;
         m_if_rd = NOP; m_dm_rd = 0;
      end else begin
         m_ifv = 0;
         m_dmv = 0;
         if (m_owner == 0) begin
            m_waited = 0;
            if (if_req && (!dm_req || m_streak == MAX_STREAK)) begin
               m_owner = 1; m_addr = if_addr; m_wdata = 0; m_f3 = 3'b010; m_we = 0;
               m_streak = 0;
            end else if (dm_req) begin
               m_owner = 2; m_addr = dm_addr; m_wdata = dm_wdata; m_f3 = dm_funct3; m_we = dm_we;
               m_streak = if_req ? ((m_streak < 7) ? m_streak + 1 : 7) : 0;
            end
         end else if (mem_ready || m_waited + 1 == TIMEOUT) begin
            rd = mem_ready ? mem_rdata : ((m_owner == 1) ? NOP : 32'h0);
            if (!mem_ready) m_err = 1;
            if (m_owner == 1) begin m_ifv = 1; m_if_rd = rd; end
            else begin m_dmv = 1; m_dm_rd = rd; end
            m_owner = 0;
         end else begin
            m_waited++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("mem_req",    32'(mem_req),    32'(m_owner != 0));
      check("mem_we",     32'(mem_we),     32'(m_owner == 2 && m_we));
      check("mem_addr",   mem_addr,        m_addr);
      check("mem_wdata",  mem_wdata,       m_wdata);
      check("mem_funct3", 32'(mem_funct3), 32'(m_f3));
      check("if_valid",   32'(if_valid),   32'(m_ifv));
      check("dm_valid",   32'(dm_valid),   32'(m_dmv));
      check("if_rdata",   if_rdata,        m_if_rd);
      check("dm_rdata",   dm_rdata,        m_dm_rd);
      check("bus_err",    32'(bus_err),    32'(m_err));
      check("stall_f",    32'(stall_f),    32'(if_req & ~m_ifv));
      check("stall_m",    32'(stall_m),    32'(dm_req & ~m_dmv));
   endtask

   int seq[6];
   int exp_seq[6];
   int n_grants;
   int waited;
   logic prev_req;
   int ready_pct;

   initial begin
      reset = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
      dm_wdata = 0; dm_funct3 = 0; mem_ready = 0; mem_rdata = 0;
      m_owner = 0; m_waited = 0; m_streak = 0; m_addr = 0; m_wdata = 0; m_f3 = 0;
      m_we = 0; m_ifv = 0; m_dmv = 0; m_err = 0; m_if_rd = NOP; m_dm_rd = 0;
      #2;
      tick(); tick();
      check("rst_if_rdata", if_rdata, NOP);
      check("rst_mem_req", 32'(mem_req), 32'd0);

      // Single fetch with zero-wait memory.
      reset = 1; if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h0050_0093;
      tick();
      check("f1_busy_req", 32'(mem_req), 32'd1);
      check("f1_busy_addr", mem_addr, 32'h100);
      tick();
      check("f1_valid", 32'(if_valid), 32'd1);
      check("f1_rdata", if_rdata, 32'h0050_0093);
      check("f1_req_low", 32'(mem_req), 32'd0);
      if_req = 0;
      tick();

      // Both request together: DM first, IF after one idle gap.
      if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_funct3 = 3'b010;
      mem_rdata = 32'hAAAA_5555;
      tick();
      check("both_dm_first", mem_addr, 32'h2000);
      tick();
      check("both_dm_valid", 32'(dm_valid), 32'd1);
      check("both_stall_f", 32'(stall_f), 32'd1);
      dm_req = 0;
      tick();
      check("both_if_second", mem_addr, 32'h104);
      tick();
      check("both_if_valid", 32'(if_valid), 32'd1);
      if_req = 0;
      tick();

      // Fetch that never gets mem_ready times out.
      if_req = 1; if_addr = 32'h200; mem_ready = 0;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!if_valid && waited < 40);
      check("to_cycles", 32'(waited), 32'd16);
      check("to_rdata", if_rdata, NOP);
      check("to_bus_err", 32'(bus_err), 32'd1);
      if_req = 0;
      repeat (3) tick();
      check("to_sticky", 32'(bus_err), 32'd1);

      // Reset during the second busy cycle of a store.
      dm_req = 1; dm_we = 1; dm_addr = 32'h3000; dm_wdata = 32'hDEAD_BEEF; dm_funct3 = 3'b010;
      tick();
      dm_addr = 32'h3F00;
      tick();
      check("rb_hold_addr", mem_addr, 32'h3000);
      check("rb_hold_we", 32'(mem_we), 32'd1);
      reset = 0;
      tick();
      check("rb_req", 32'(mem_req), 32'd0);
      check("rb_we", 32'(mem_we), 32'd0);
      check("rb_dm_valid", 32'(dm_valid), 32'd0);
      check("rb_bus_err", 32'(bus_err), 32'd0);
      reset = 1; dm_req = 0;
      tick();

      // Back-to-back stores with fetch pending: 4 DM, 1 IF, then DM.
      exp_seq[0] = 2; exp_seq[1] = 2; exp_seq[2] = 2; exp_seq[3] = 2; exp_seq[4] = 1; exp_seq[5] = 2;
      if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 1; dm_addr = 32'h5000; mem_ready = 1;
      n_grants = 0; prev_req = 0;
      for (int c = 0; c < 60 && n_grants < 6; c++) begin
         tick();
         if (mem_req && !prev_req) begin
            seq[n_grants] = (mem_addr == 32'h400) ? 1 : 2;
            n_grants++;
         end
         prev_req = mem_req;
      end
      check("streak_grants", 32'(n_grants), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("streak_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
      if_req = 0; dm_req = 0;
      tick(); tick();

      // Randomized traffic.
      ready_pct = 100;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            case ($urandom_range(0, 3))
               0: ready_pct = 100;
               1: ready_pct = 60;
               2: ready_pct = 25;
               default: ready_pct = 2;
            endcase
         end
         tick();
         reset = ($urandom_range(0, 299) != 0);
         mem_ready = ($urandom_range(0, 99) < ready_pct);
         mem_rdata = $urandom;
         if (if_req && if_valid) begin
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = {$urandom_range(0, 32'hFFFF), 2'b00};
         end else if (!if_req) begin
            if_req = ($urandom_range(0, 2) == 0);
            if_addr = {$urandom_range(0, 32'hFFFF), 2'b00};
         end else if (m_owner != 1 && $urandom_range(0, 15) == 0) begin
            if_req = 0;
         end else if (m_owner == 1 && $urandom_range(0, 3) == 0) begin
            if_addr = $urandom;
         end
         if ((dm_req && dm_valid) || !dm_req) begin
            dm_req = (dm_req && dm_valid) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            dm_we = $urandom_range(0, 1);
            dm_addr = $urandom;
            dm_wdata = $urandom;
            dm_funct3 = $urandom_range(0, 7);
         end else if (m_owner != 2 && $urandom_range(0, 15) == 0) begin
            dm_req = 0;
         end else if (m_owner == 2 && $urandom_range(0, 2) == 0) begin
            dm_addr = $urandom;
            dm_wdata = $urandom;
            dm_we = $urandom_range(0, 1);
            dm_funct3 = $urandom_range(0, 7);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
